btb_assoc: RTL and testbench
============================

# btb_assoc

Parametrised set-associative branch target buffer with an integrated return address stack, for the fetch stage of the CPU. It takes the fetch PC in cycle t and returns a prediction for that PC in cycle t+1. It adds several things its predecessor lacks:
- configurable way count and depth,
- per-entry valid bits cleared by reset,
- round-robin replacement,
- false-hit invalidation,
- a sweep-based flush with a busy handshake.

## Interface
Parameters:
- ENTRIES, 4096: total entries, power of two.
- WAYS, 2: associativity, power of two, 1..8. SETS = ENTRIES/WAYS, IDX_W = log2(SETS).
- TAG_W, 9: folded tag width. Elaboration error if IDX_W+3+2*TAG_W > 32.
- RAS_DEPTH, 8: RAS entries, power of two.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low.
- stall  in  1  freezes the lookup register and suppresses RAS push/pop.
- lookup_pc  in  32  fetch PC, cycle t.
- pred_pc  out  32  PC the current prediction belongs to (registered lookup_pc).
- pred_hit  out  1  valid tag match.
- pred_type  out  BranchType_e  None/Call/Return/Other.
- pred_target  out  32  predicted target.
- pred_loc  out  1  stored location bit.
- upd_valid  in  1  resolved-branch update.
- upd_pc  in  32  PC of the update.
- upd_target  in  32  target of the update.
- upd_type  in  BranchType_e  branch type of the update.
- upd_loc  in  1  location bit of the update.
- upd_taken  in  1  resolved direction.
- upd_mispredict  in  1  update was mispredicted.
- flush_req  in  1  single-cycle request to invalidate all entries.
- flush_busy  out  1  high while the sweep runs.

## Operation
Addressing and storage:
- index = pc[IDX_W+2:3].
- tag = pc[IDX_W+3 +: TAG_W] ^ pc[IDX_W+3+TAG_W +: TAG_W].
- Entry = {valid, tag, target, type, loc}. Valid bits are flops and are cleared by reset. Other fields have no reset.

Lookup:
- The lookup register captures lookup_pc on every non-stall edge.
- Arrays are read combinationally using the registered index.
- Hit means any way of the set is valid with a matching tag and type != None. At most one way hits; the lowest-numbered way wins.

Prediction on a hit:
- Call: target = entry target. Push pred_pc+12 if loc=1, otherwise pred_pc+8.
- Return with RAS non-empty: target = RAS top, then pop.
- Return with RAS empty: target = pred_pc+8.
- Other: target = entry target.

Prediction on a miss:
- pred_hit=0, pred_type=None, pred_loc=0, pred_target=pred_pc+8.

Writes (on upd_valid && upd_mispredict):
- If upd_taken=1, allocate or overwrite.
  - Way choice: the hitting way if upd tag matches; else the lowest invalid way; else the set's round-robin pointer.
  - The pointer (log2(WAYS) bits per set) advances mod WAYS only when it was used as the victim.
- If upd_taken=0 and a way matches, clear that way's valid bit.
- Other updates are ignored.

RAS:
- Circular buffer with a saturating count.
- Push on full overwrites the oldest entry; count stays at RAS_DEPTH.
- Pop on empty is never issued.
- Push and pop are suppressed when stall=1 or flush_busy=1.

Flush FSM (IDLE, SWEEP):
- IDLE: flush_req moves to SWEEP with the set counter at 0.
- SWEEP: clear the valid bits of all ways of counter set, one set per cycle. Exit to IDLE after set SETS-1.
- During SWEEP: flush_busy=1, pred_hit forced to 0, updates dropped, flush_req ignored.
- The RAS is emptied on entry to SWEEP.

## Timing
- Lookup latency is 1 cycle: lookup_pc at edge t is reflected in pred_* after edge t.
- An update written at edge t is visible to any prediction evaluated after edge t, including a prediction for a PC registered at the same edge. No further forwarding.
- stall=1: the lookup register holds and pred_* are re-evaluated from the current arrays. Updates still apply.
- The flush sweep takes exactly SETS cycles.
- Reset, including reset asserted mid-sweep, sets:
  - FSM to IDLE; flush_busy=0;
  - pred_pc=32'hBFC0_0000, pred_target=32'hBFC0_0008, pred_hit=0, pred_type=None, pred_loc=0;
  - all valid bits 0, round-robin pointers 0, RAS count 0.
- A simultaneous update and flush_req in IDLE applies the update first; the sweep then clears it.

## Structure
- btb_pkg holds: Vaddr, BranchType_e, the entry struct, the cal_tag function (parametrised by TAG_W/IDX_W), and the reset PC constant 32'hBFC0_0000.
- One sub-module, btb_ras (parameter RAS_DEPTH): push/pop/data/valid-top interface, asynchronous active-low reset, synchronous clear input used at flush.

## Test plan
- After reset, lookup 0xBFC0_0000 → pred_hit=0, pred_target=0xBFC0_0008.
- Update pc=0x8000_0010, target=0x8000_0400, type=Other, taken, mispredict; then lookup 0x8000_0010 → pred_hit=1, pred_target=0x8000_0400.
- WAYS=2: allocate three distinct tags into the same set → the third evicts way0 (pointer 0→1); a fourth evicts way1.
- Call hit at 0x8000_0020 with loc=0, then a Return hit → pred_target=0x8000_0028. With RAS_DEPTH=8, push 9 calls then pop 8 → the oldest value is lost and the 9th pop sees an empty RAS (target = pred_pc+8).
- Not-taken mispredict on a hit entry → the next lookup of that PC misses. Other ways of the set are unaffected.
- flush_req after filling entries → flush_busy=1 for SETS cycles and pred_hit=0 throughout. All lookups miss afterwards. Reset mid-sweep drops flush_busy immediately.

Source files
------------

// File: rtl/btb_pkg.sv
// Shared types, constants and the tag-folding helper for the branch target buffer.
package btb_pkg;

    typedef logic [31:0] Vaddr;

    typedef enum logic [1:0] {
        BR_NONE   = 2'd0,
        BR_CALL   = 2'd1,
        BR_RETURN = 2'd2,
        BR_OTHER  = 2'd3
    } BranchType_e;

    typedef enum logic {
        FL_IDLE  = 1'b0,
        FL_SWEEP = 1'b1
    } flush_state_e;

    localparam Vaddr RESET_PC = 32'hBFC0_0000;

    // IDX_W+3+2*TAG_W <= 32 bounds any legal folded tag to 14 bits.
    localparam int TAG_W_MAX = 14;

    // Stored payload of one way; the valid bit lives in a separate reset flop array.
    typedef struct packed {
        logic [TAG_W_MAX-1:0] tag;
        Vaddr                 target;
        BranchType_e          btype;
        logic                 loc;
    } btb_entry_t;

    function automatic logic [TAG_W_MAX-1:0] cal_tag(input Vaddr pc, input int idx_w,
                                                    input int tag_w);
        Vaddr lo;
        Vaddr hi;
        Vaddr mask;
        Vaddr folded;
        lo     = pc >> (idx_w + 3);
        hi     = lo >> tag_w;
        mask   = (Vaddr'(1) << tag_w) - Vaddr'(1);
        folded = (lo ^ hi) & mask;
        return folded[TAG_W_MAX-1:0];
    endfunction

endpackage

// File: rtl/btb_ras.sv
// Return address stack: circular buffer with a saturating occupancy count.
module btb_ras
    import btb_pkg::*;
#(
    parameter int RAS_DEPTH = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic push,
    input  logic pop,
    input  Vaddr push_data,
    output Vaddr top_data,
    output logic top_valid
);

    localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int CNT_W = $clog2(RAS_DEPTH + 1);

    Vaddr             stack_q [RAS_DEPTH];
    logic [PTR_W-1:0] tos_q;
    logic [PTR_W-1:0] tos_inc;
    logic [PTR_W-1:0] tos_dec;
    logic [CNT_W-1:0] count_q;

    always_comb begin
        tos_inc = (tos_q == PTR_W'(RAS_DEPTH - 1)) ? '0 : tos_q + 1'b1;
        tos_dec = (tos_q == '0) ? PTR_W'(RAS_DEPTH - 1) : tos_q - 1'b1;
    end

    assign top_data  = stack_q[tos_q];
    assign top_valid = (count_q != '0);

    // A push on a full stack lands on the oldest slot, so the count saturates.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tos_q   <= '0;
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (push) begin
            tos_q <= tos_inc;
            if (count_q != CNT_W'(RAS_DEPTH)) count_q <= count_q + 1'b1;
        end else if (pop) begin
            tos_q   <= tos_dec;
            count_q <= count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!clear && push) stack_q[tos_inc] <= push_data;
    end

endmodule

// File: rtl/btb_assoc.sv
// Set-associative branch target buffer with round-robin replacement, an integrated
// return address stack and a one-set-per-cycle flush sweep.
module btb_assoc
    import btb_pkg::*;
#(
    parameter int ENTRIES   = 4096,
    parameter int WAYS      = 2,
    parameter int TAG_W     = 9,
    parameter int RAS_DEPTH = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         stall,
    input  Vaddr         lookup_pc,
    output Vaddr         pred_pc,
    output logic         pred_hit,
    output BranchType_e  pred_type,
    output Vaddr         pred_target,
    output logic         pred_loc,
    input  logic         upd_valid,
    input  Vaddr         upd_pc,
    input  Vaddr         upd_target,
    input  BranchType_e  upd_type,
    input  logic         upd_loc,
    input  logic         upd_taken,
    input  logic         upd_mispredict,
    input  logic         flush_req,
    output logic         flush_busy,
    output flush_state_e dbg_flush_state
);

    localparam int SETS  = ENTRIES / WAYS;
    localparam int IDX_W = $clog2(SETS);
    localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

    if (IDX_W + 3 + 2 * TAG_W > 32) begin : g_bad_tag_w
        $error("btb_assoc: IDX_W+3+2*TAG_W must not exceed 32");
    end
    if ((WAYS < 1) || (WAYS > 8) || ((WAYS & (WAYS - 1)) != 0)) begin : g_bad_ways
        $error("btb_assoc: WAYS must be a power of two in 1..8");
    end

    // Handshakes: upd_valid is a one-cycle strobe with no back-pressure and is
    // dropped while flush_busy is high; flush_req is a one-cycle strobe accepted
    // only when flush_busy is low, and flush_busy stays high for the whole sweep.

    btb_entry_t                 entry_q [WAYS][SETS];
    logic [SETS-1:0][WAYS-1:0]  valid_q;
    logic [SETS-1:0][WAY_W-1:0] rr_q;

    Vaddr                 pc_q;
    logic [IDX_W-1:0]     rd_idx;
    logic [TAG_W_MAX-1:0] rd_tag;
    logic                 rd_hit;
    logic [WAY_W-1:0]     rd_way;
    Vaddr                 rd_target;
    BranchType_e          rd_btype;
    logic                 rd_loc;

    logic                 ras_clear;
    logic                 ras_push;
    logic                 ras_pop;
    Vaddr                 ras_push_data;
    Vaddr                 ras_top;
    logic                 ras_valid;

    logic [IDX_W-1:0]     wr_idx;
    logic [TAG_W_MAX-1:0] wr_tag;
    logic                 upd_match;
    logic [WAY_W-1:0]     match_way;
    logic                 has_free;
    logic [WAY_W-1:0]     free_way;
    logic [WAY_W-1:0]     wr_way;
    logic [WAY_W-1:0]     rr_next;
    logic                 upd_en;
    logic                 wr_alloc;
    logic                 wr_inval;
    logic                 use_rr;

    flush_state_e         state_q;
    flush_state_e         state_d;
    logic [IDX_W-1:0]     cnt_q;
    logic [IDX_W-1:0]     cnt_d;
    logic                 sweep_clr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)      pc_q <= RESET_PC;
        else if (!stall) pc_q <= lookup_pc;
    end

    assign rd_idx = pc_q[IDX_W+2:3];
    assign rd_tag = cal_tag(pc_q, IDX_W, TAG_W);

    // Descending scan so the lowest-numbered matching way is the one kept.
    always_comb begin
        rd_hit = 1'b0;
        rd_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (valid_q[rd_idx][WAY_W'(w)] && (entry_q[WAY_W'(w)][rd_idx].tag == rd_tag) &&
                (entry_q[WAY_W'(w)][rd_idx].btype != BR_NONE)) begin
                rd_hit = 1'b1;
                rd_way = WAY_W'(w);
            end
        end
        rd_target = entry_q[rd_way][rd_idx].target;
        rd_btype  = entry_q[rd_way][rd_idx].btype;
        rd_loc    = entry_q[rd_way][rd_idx].loc;
    end

    always_comb begin
        pred_pc       = pc_q;
        pred_hit      = rd_hit && !flush_busy;
        pred_type     = BR_NONE;
        pred_loc      = 1'b0;
        pred_target   = pc_q + 32'd8;
        ras_push      = 1'b0;
        ras_pop       = 1'b0;
        ras_push_data = pc_q + (rd_loc ? 32'd12 : 32'd8);
        if (pred_hit) begin
            pred_type = rd_btype;
            pred_loc  = rd_loc;
            case (rd_btype)
                BR_CALL: begin
                    pred_target = rd_target;
                    ras_push    = 1'b1;
                end
                BR_RETURN: begin
                    if (ras_valid) begin
                        pred_target = ras_top;
                        ras_pop     = 1'b1;
                    end
                end
                default: pred_target = rd_target;
            endcase
        end
        if (stall || flush_busy) begin
            ras_push = 1'b0;
            ras_pop  = 1'b0;
        end
    end

    btb_ras #(
        .RAS_DEPTH(RAS_DEPTH)
    ) u_ras (
        .clk      (clk),
        .reset    (reset),
        .clear    (ras_clear),
        .push     (ras_push),
        .pop      (ras_pop),
        .push_data(ras_push_data),
        .top_data (ras_top),
        .top_valid(ras_valid)
    );

    // Update way choice: matching way, else lowest invalid way, else the set's pointer.
    always_comb begin
        wr_idx    = upd_pc[IDX_W+2:3];
        wr_tag    = cal_tag(upd_pc, IDX_W, TAG_W);
        upd_match = 1'b0;
        match_way = '0;
        has_free  = 1'b0;
        free_way  = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (valid_q[wr_idx][WAY_W'(w)] && (entry_q[WAY_W'(w)][wr_idx].tag == wr_tag)) begin
                upd_match = 1'b1;
                match_way = WAY_W'(w);
            end
            if (!valid_q[wr_idx][WAY_W'(w)]) begin
                has_free = 1'b1;
                free_way = WAY_W'(w);
            end
        end
        upd_en   = upd_valid && upd_mispredict && (state_q == FL_IDLE);
        wr_alloc = upd_en && upd_taken;
        wr_inval = upd_en && !upd_taken && upd_match;
        use_rr   = wr_alloc && !upd_match && !has_free;
        if (upd_match)     wr_way = match_way;
        else if (has_free) wr_way = free_way;
        else               wr_way = rr_q[wr_idx];
        rr_next = (rr_q[wr_idx] == WAY_W'(WAYS - 1)) ? '0 : rr_q[wr_idx] + 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= '0;
            rr_q    <= '0;
        end else begin
            if (sweep_clr) valid_q[cnt_q] <= '0;
            if (wr_alloc)  valid_q[wr_idx][wr_way] <= 1'b1;
            if (wr_inval)  valid_q[wr_idx][wr_way] <= 1'b0;
            if (use_rr)    rr_q[wr_idx] <= rr_next;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_alloc) begin
            entry_q[wr_way][wr_idx] <= '{tag: wr_tag, target: upd_target, btype: upd_type,
                                         loc: upd_loc};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= FL_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        flush_busy = 1'b0;
        sweep_clr  = 1'b0;
        ras_clear  = 1'b0;
        case (state_q)
            FL_IDLE: begin
                if (flush_req) begin
                    state_d   = FL_SWEEP;
                    cnt_d     = '0;
                    ras_clear = 1'b1;
                end
            end
            FL_SWEEP: begin
                flush_busy = 1'b1;
                sweep_clr  = 1'b1;
                if (cnt_q == IDX_W'(SETS - 1)) state_d = FL_IDLE;
                else                           cnt_d   = cnt_q + 1'b1;
            end
            default: state_d = FL_IDLE;
        endcase
    end

    assign dbg_flush_state = state_q;

endmodule

// File: tb/tb_btb_assoc.sv
// Directed bench for btb_assoc at default parameters (2048 sets x 2 ways, RAS depth 8).
module tb_btb_assoc;
    import btb_pkg::*;

    localparam int   SETS    = 2048;
    localparam Vaddr IDLE_PC = 32'h4000_0000;
    localparam Vaddr X_PC    = 32'h8000_0010;
    localparam Vaddr CALL_PC = 32'h8000_0020;
    localparam Vaddr RET_PC  = 32'h8000_0100;

    logic         clk = 1'b0;
    logic         reset;
    logic         stall;
    Vaddr         lookup_pc;
    Vaddr         pred_pc;
    logic         pred_hit;
    BranchType_e  pred_type;
    Vaddr         pred_target;
    logic         pred_loc;
    logic         upd_valid;
    Vaddr         upd_pc;
    Vaddr         upd_target;
    BranchType_e  upd_type;
    logic         upd_loc;
    logic         upd_taken;
    logic         upd_mispredict;
    logic         flush_req;
    logic         flush_busy;
    flush_state_e dbg_flush_state;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    btb_assoc dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .lookup_pc      (lookup_pc),
        .pred_pc        (pred_pc),
        .pred_hit       (pred_hit),
        .pred_type      (pred_type),
        .pred_target    (pred_target),
        .pred_loc       (pred_loc),
        .upd_valid      (upd_valid),
        .upd_pc         (upd_pc),
        .upd_target     (upd_target),
        .upd_type       (upd_type),
        .upd_loc        (upd_loc),
        .upd_taken      (upd_taken),
        .upd_mispredict (upd_mispredict),
        .flush_req      (flush_req),
        .flush_busy     (flush_busy),
        .dbg_flush_state(dbg_flush_state)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_update(input Vaddr pc, input Vaddr target, input BranchType_e t,
                             input logic loc, input logic taken);
        lookup_pc      = IDLE_PC;
        upd_pc         = pc;
        upd_target     = target;
        upd_type       = t;
        upd_loc        = loc;
        upd_taken      = taken;
        upd_mispredict = 1'b1;
        upd_valid      = 1'b1;
        step();
        upd_valid      = 1'b0;
    endtask

    task automatic lookup(input Vaddr pc);
        lookup_pc = pc;
        step();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        stall = 1'b0;
        lookup_pc = RESET_PC;
        upd_valid = 1'b0;
        upd_pc = '0;
        upd_target = '0;
        upd_type = BR_NONE;
        upd_loc = 1'b0;
        upd_taken = 1'b0;
        upd_mispredict = 1'b0;
        flush_req = 1'b0;
        step();
        step();
        checks++;
        if ({pred_pc, pred_target} !== {32'hBFC0_0000, 32'hBFC0_0008}) begin
            failures++;
            $display("FAIL reset_pc: got pc=%h target=%h want pc=bfc00000 target=bfc00008",
                     pred_pc, pred_target);
        end
        checks++;
        if ({pred_hit, pred_type, pred_loc, flush_busy, dbg_flush_state} !==
            {1'b0, BR_NONE, 1'b0, 1'b0, FL_IDLE}) begin
            failures++;
            $display("FAIL reset_flags: got hit=%0b type=%0d loc=%0b busy=%0b state=%0d want 0/0/0/0/0",
                     pred_hit, pred_type, pred_loc, flush_busy, dbg_flush_state);
        end
        reset = 1'b1;
        lookup(RESET_PC);
        checks++;
        if ({pred_hit, pred_pc, pred_target} !== {1'b0, 32'hBFC0_0000, 32'hBFC0_0008}) begin
            failures++;
            $display("FAIL reset_lookup: got hit=%0b pc=%h target=%h want hit=0 pc=bfc00000 target=bfc00008",
                     pred_hit, pred_pc, pred_target);
        end
    endtask

    task automatic test_update();
        do_update(X_PC, 32'h8000_0400, BR_OTHER, 1'b0, 1'b1);
        lookup(X_PC);
        checks++;
        if ({pred_hit, pred_type, pred_target, pred_loc} !== {1'b1, BR_OTHER, 32'h8000_0400, 1'b0}) begin
            failures++;
            $display("FAIL update_hit: got hit=%0b type=%0d target=%h loc=%0b want 1/3/80000400/0",
                     pred_hit, pred_type, pred_target, pred_loc);
        end
    endtask

    task automatic test_call_return();
        do_update(CALL_PC, 32'h8000_1000, BR_CALL, 1'b0, 1'b1);
        do_update(RET_PC, 32'h1234_5678, BR_RETURN, 1'b0, 1'b1);
        lookup(CALL_PC);
        checks++;
        if ({pred_hit, pred_type, pred_target} !== {1'b1, BR_CALL, 32'h8000_1000}) begin
            failures++;
            $display("FAIL call_hit: got hit=%0b type=%0d target=%h want 1/1/80001000",
                     pred_hit, pred_type, pred_target);
        end
        lookup(RET_PC);
        checks++;
        if ({pred_hit, pred_type, pred_target} !== {1'b1, BR_RETURN, 32'h8000_0028}) begin
            failures++;
            $display("FAIL return_pop: got hit=%0b type=%0d target=%h want 1/2/80000028",
                     pred_hit, pred_type, pred_target);
        end
        lookup(IDLE_PC);
        checks++;
        if ({pred_hit, pred_target} !== {1'b0, 32'h4000_0008}) begin
            failures++;
            $display("FAIL miss_target: got hit=%0b target=%h want 0/40000008", pred_hit, pred_target);
        end
        lookup(RET_PC);
        checks++;
        if ({pred_hit, pred_target} !== {1'b1, 32'h8000_0108}) begin
            failures++;
            $display("FAIL return_empty: got hit=%0b target=%h want 1/80000108", pred_hit, pred_target);
        end
    endtask

    // Nine calls overflow the 8-deep stack; a small queue model tracks what should remain.
    task automatic test_back_to_back();
        Vaddr exp_q[$];
        Vaddr pc;
        Vaddr want;
        logic loc;
        for (int i = 1; i < 9; i++) begin
            do_update(CALL_PC + 32'(8 * i), 32'h9000_0000 + 32'(i), BR_CALL, (i % 2) == 1, 1'b1);
        end
        for (int i = 0; i < 9; i++) begin
            pc  = CALL_PC + 32'(8 * i);
            loc = (i % 2) == 1;
            lookup(pc);
            checks++;
            if ({pred_hit, pred_type, pred_loc} !== {1'b1, BR_CALL, loc}) begin
                failures++;
                $display("FAIL b2b_call%0d: got hit=%0b type=%0d loc=%0b want 1/1/%0b",
                         i, pred_hit, pred_type, pred_loc, loc);
            end
            if (exp_q.size() == 8) void'(exp_q.pop_front());
            exp_q.push_back(pc + (loc ? 32'd12 : 32'd8));
        end
        for (int k = 0; k < 8; k++) begin
            lookup(RET_PC);
            want = exp_q.pop_back();
            checks++;
            if (pred_target !== want) begin
                failures++;
                $display("FAIL b2b_pop%0d: got target=%h want %h", k, pred_target, want);
            end
        end
        lookup(RET_PC);
        checks++;
        if (pred_target !== 32'h8000_0108) begin
            failures++;
            $display("FAIL b2b_pop_empty: got target=%h want 80000108", pred_target);
        end
        lookup(IDLE_PC);
    endtask

    task automatic test_replacement();
        do_update(32'h0000_0200, 32'h0000_0A00, BR_OTHER, 1'b0, 1'b1);
        do_update(32'h0000_4200, 32'h0000_0B00, BR_OTHER, 1'b0, 1'b1);
        do_update(32'h0000_8200, 32'h0000_0C00, BR_OTHER, 1'b0, 1'b1);
        lookup(32'h0000_0200);
        checks++;
        if ({pred_hit, pred_target} !== {1'b0, 32'h0000_0208}) begin
            failures++;
            $display("FAIL evict_way0: got hit=%0b target=%h want 0/00000208", pred_hit, pred_target);
        end
        lookup(32'h0000_4200);
        checks++;
        if ({pred_hit, pred_target} !== {1'b1, 32'h0000_0B00}) begin
            failures++;
            $display("FAIL keep_b: got hit=%0b target=%h want 1/00000b00", pred_hit, pred_target);
        end
        do_update(32'h0000_C200, 32'h0000_0D00, BR_OTHER, 1'b0, 1'b1);
        lookup(32'h0000_4200);
        checks++;
        if (pred_hit !== 1'b0) begin
            failures++;
            $display("FAIL evict_way1: got hit=%0b want 0", pred_hit);
        end
        lookup(32'h0000_8200);
        checks++;
        if ({pred_hit, pred_target} !== {1'b1, 32'h0000_0C00}) begin
            failures++;
            $display("FAIL keep_c: got hit=%0b target=%h want 1/00000c00", pred_hit, pred_target);
        end
        lookup(32'h0000_C200);
        checks++;
        if ({pred_hit, pred_target} !== {1'b1, 32'h0000_0D00}) begin
            failures++;
            $display("FAIL alloc_d: got hit=%0b target=%h want 1/00000d00", pred_hit, pred_target);
        end
    endtask

    task automatic test_not_taken();
        do_update(32'h0000_C200, 32'h0000_0000, BR_OTHER, 1'b0, 1'b0);
        lookup(32'h0000_C200);
        checks++;
        if ({pred_hit, pred_target} !== {1'b0, 32'h0000_C208}) begin
            failures++;
            $display("FAIL not_taken_inval: got hit=%0b target=%h want 0/0000c208", pred_hit, pred_target);
        end
        lookup(32'h0000_8200);
        checks++;
        if ({pred_hit, pred_target} !== {1'b1, 32'h0000_0C00}) begin
            failures++;
            $display("FAIL not_taken_other_way: got hit=%0b target=%h want 1/00000c00",
                     pred_hit, pred_target);
        end
    endtask

    task automatic test_stall();
        lookup(X_PC);
        stall = 1'b1;
        do_update(X_PC, 32'h8000_0500, BR_OTHER, 1'b0, 1'b1);
        checks++;
        if ({pred_pc, pred_hit, pred_target} !== {X_PC, 1'b1, 32'h8000_0500}) begin
            failures++;
            $display("FAIL stall_hold: got pc=%h hit=%0b target=%h want %h/1/80000500",
                     pred_pc, pred_hit, pred_target, X_PC);
        end
        stall = 1'b0;
        lookup(IDLE_PC);
        checks++;
        if (pred_pc !== IDLE_PC) begin
            failures++;
            $display("FAIL stall_release: got pc=%h want %h", pred_pc, IDLE_PC);
        end
    endtask

    task automatic test_same_edge();
        lookup_pc = 32'h8000_0800;
        upd_pc = 32'h8000_0800;
        upd_target = 32'h8000_0A04;
        upd_type = BR_OTHER;
        upd_loc = 1'b1;
        upd_taken = 1'b1;
        upd_mispredict = 1'b1;
        upd_valid = 1'b1;
        step();
        upd_valid = 1'b0;
        checks++;
        if ({pred_hit, pred_target, pred_loc} !== {1'b1, 32'h8000_0A04, 1'b1}) begin
            failures++;
            $display("FAIL same_edge: got hit=%0b target=%h loc=%0b want 1/80000a04/1",
                     pred_hit, pred_target, pred_loc);
        end
        upd_pc = 32'h8000_0900;
        upd_mispredict = 1'b0;
        upd_valid = 1'b1;
        lookup_pc = IDLE_PC;
        step();
        upd_valid = 1'b0;
        lookup(32'h8000_0900);
        checks++;
        if (pred_hit !== 1'b0) begin
            failures++;
            $display("FAIL no_mispredict_ignored: got hit=%0b want 0", pred_hit);
        end
    endtask

    task automatic test_flush();
        Vaddr miss_pcs[6];
        int   bad;
        miss_pcs = '{X_PC, CALL_PC, 32'h0000_8200, 32'h8000_0800, 32'h8000_0A00, 32'h8000_0B00};
        lookup(CALL_PC);
        flush_req = 1'b1;
        lookup_pc = X_PC;
        upd_pc = 32'h8000_0A00;
        upd_target = 32'h8000_0C00;
        upd_type = BR_OTHER;
        upd_loc = 1'b0;
        upd_taken = 1'b1;
        upd_mispredict = 1'b1;
        upd_valid = 1'b1;
        step();
        flush_req = 1'b0;
        upd_valid = 1'b0;
        checks++;
        if (dbg_flush_state !== FL_SWEEP) begin
            failures++;
            $display("FAIL flush_enter: got state=%0d want 1", dbg_flush_state);
        end
        bad = 0;
        for (int i = 0; i < SETS; i++) begin
            if ((flush_busy !== 1'b1) || (pred_hit !== 1'b0)) bad++;
            if (i == 5) begin
                upd_pc = 32'h8000_0B00;
                upd_valid = 1'b1;
                flush_req = 1'b1;
            end
            step();
            upd_valid = 1'b0;
            flush_req = 1'b0;
        end
        checks++;
        if (bad !== 0) begin
            failures++;
            $display("FAIL flush_busy_window: got %0d bad cycles want 0", bad);
        end
        checks++;
        if ({flush_busy, dbg_flush_state} !== {1'b0, FL_IDLE}) begin
            failures++;
            $display("FAIL flush_exit: got busy=%0b state=%0d want 0/0", flush_busy, dbg_flush_state);
        end
        for (int i = 0; i < 6; i++) begin
            lookup(miss_pcs[i]);
            checks++;
            if ({pred_hit, pred_target} !== {1'b0, miss_pcs[i] + 32'd8}) begin
                failures++;
                $display("FAIL post_flush_miss%0d: got hit=%0b target=%h want 0/%h",
                         i, pred_hit, pred_target, miss_pcs[i] + 32'd8);
            end
        end
        do_update(RET_PC, 32'h1234_5678, BR_RETURN, 1'b0, 1'b1);
        lookup(RET_PC);
        checks++;
        if ({pred_hit, pred_type, pred_target} !== {1'b1, BR_RETURN, 32'h8000_0108}) begin
            failures++;
            $display("FAIL flush_ras_empty: got hit=%0b type=%0d target=%h want 1/2/80000108",
                     pred_hit, pred_type, pred_target);
        end
        lookup(IDLE_PC);
    endtask

    task automatic test_reset_mid_sweep();
        do_update(32'h8000_0060, 32'h8000_0E00, BR_OTHER, 1'b0, 1'b1);
        flush_req = 1'b1;
        step();
        flush_req = 1'b0;
        step();
        step();
        step();
        checks++;
        if (flush_busy !== 1'b1) begin
            failures++;
            $display("FAIL mid_sweep_busy: got busy=%0b want 1", flush_busy);
        end
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if ({flush_busy, dbg_flush_state, pred_hit, pred_pc, pred_target} !==
            {1'b0, FL_IDLE, 1'b0, 32'hBFC0_0000, 32'hBFC0_0008}) begin
            failures++;
            $display("FAIL reset_mid_sweep: got busy=%0b state=%0d hit=%0b pc=%h target=%h want 0/0/0/bfc00000/bfc00008",
                     flush_busy, dbg_flush_state, pred_hit, pred_pc, pred_target);
        end
        step();
        reset = 1'b1;
        lookup(32'h8000_0060);
        checks++;
        if ({pred_hit, pred_target} !== {1'b0, 32'h8000_0068}) begin
            failures++;
            $display("FAIL reset_clears_valid: got hit=%0b target=%h want 0/80000068",
                     pred_hit, pred_target);
        end
    endtask

    initial begin
        test_reset();
        test_update();
        test_call_return();
        test_back_to_back();
        test_replacement();
        test_not_taken();
        test_stall();
        test_same_edge();
        test_flush();
        test_reset_mid_sweep();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
